// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and helpers for the data-memory responder.
//   - AM_* : core access-mode encodings (byte / half / word / reserved)
//   - dmem_state_t : responder FSM states
//   - dmem_req_t : request fields held for the duration of an access
//   - is_misaligned() : alignment rule for a given mode and address LSBs
package dmem_pkg;

    localparam logic [1:0] AM_BYTE = 2'b00;
    localparam logic [1:0] AM_HALF = 2'b01;
    localparam logic [1:0] AM_WORD = 2'b10;
    localparam logic [1:0] AM_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_t;

    // Address is held separately because its width follows ADDR_WIDTH.
    typedef struct packed {
        logic        we;
        logic [31:0] wdata;
        logic [1:0]  mode;
        logic        uns;
    } dmem_req_t;

    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] mode);
        logic mis;
        case (mode)
            AM_BYTE: mis = 1'b0;
            AM_HALF: mis = addr_lo[0];
            AM_WORD: mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align
//   Purely combinational lane steering for the data-memory responder.
//   Ports:
//     rd_word       in  32  RAM word at the accessed word index
//     st_data       in  32  store data, byte/half data in the low bits
//     addr_lo       in  2   byte offset within the word
//     mode          in  2   access mode (AM_*)
//     load_unsigned in  1   1 = zero-extend byte/half loads
//     load_val      out 32  right-justified, extended load result
//     wr_word       out 32  store data replicated onto every candidate lane
//     byte_en       out 4   lanes written by a store (not gated by alignment)
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mode,
    input  logic        load_unsigned,
    output logic [31:0] load_val,
    output logic [31:0] wr_word,
    output logic [3:0]  byte_en
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rd_word[7:0];
            2'd1:    byte_sel = rd_word[15:8];
            2'd2:    byte_sel = rd_word[23:16];
            default: byte_sel = rd_word[31:24];
        endcase
        half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_val = 32'd0;
        wr_word  = st_data;
        byte_en  = 4'b0000;
        case (mode)
            AM_BYTE: begin
                load_val = {{24{~load_unsigned & byte_sel[7]}}, byte_sel};
                wr_word  = {4{st_data[7:0]}};
                byte_en  = 4'b0001 << addr_lo;
            end
            AM_HALF: begin
                load_val = {{16{~load_unsigned & half_sel[15]}}, half_sel};
                wr_word  = {2{st_data[15:0]}};
                byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            AM_WORD: begin
                load_val = rd_word;
                byte_en  = 4'b1111;
            end
            default: begin
                load_val = 32'd0;
                byte_en  = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
//   Byte-addressed little-endian data RAM that answers the core's load/store
//   port after LATENCY stall cycles, followed by a one-cycle DONE response.
//   Ports:
//     clk, rst_n     clock, async active-low reset
//     req_valid      core presents a load/store this cycle
//     req_we         1 = store, 0 = load
//     addr[31:0]     byte address (bits >= ADDR_WIDTH ignored, aliasing)
//     data_in[31:0]  store data
//     access_mode    00 byte, 01 half, 10 word, 11 reserved
//     load_unsigned  zero-extend byte/half loads when 1
//     data_out[31:0] registered load result
//     stall          hold the core; combinational on req_valid only in IDLE
//     resp_valid     one-cycle pulse in DONE
//     misalign       with resp_valid: the access was rejected
//
//   state | meaning
//   IDLE  | waiting; accepts a request and latches it
//   BUSY  | counting down the remaining latency, stall held high
//   DONE  | response cycle; write/load already took effect on entry
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int    ADDR_WIDTH = 16,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    input  logic [1:0]  access_mode,
    input  logic        load_unsigned,
    output logic [31:0] data_out,
    output logic        stall,
    output logic        resp_valid,
    output logic        misalign
);

    localparam int         DEPTH    = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end
    if (ADDR_WIDTH < 3 || ADDR_WIDTH > 32) begin : g_bad_addr_width
        $error("dmem_responder: ADDR_WIDTH must be within 3..32");
    end

    // Upper address bits intentionally alias.
    if (ADDR_WIDTH < 32) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr[31:ADDR_WIDTH];
    end

    dmem_state_t           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    dmem_req_t             req_q, req_d;
    logic [31:0]           data_out_q, data_out_d;
    logic                  misalign_q, misalign_d;

    dmem_req_t             req_live, req_eff;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic                  complete;
    logic                  mis_eff;
    logic [31:0]           rd_word, wr_word, load_val;
    logic [3:0]            byte_en, lane_we;

    logic [31:0]           ram [DEPTH];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            req_q      <= '0;
            data_out_q <= 32'd0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            data_out_q <= data_out_d;
            misalign_q <= misalign_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        misalign   = 1'b0;
        case (state_q)
            ST_IDLE: stall = req_valid;
            ST_BUSY: stall = 1'b1;
            ST_DONE: begin
                resp_valid = 1'b1;
                misalign   = misalign_q;
            end
            default: ;
        endcase
    end

    assign data_out = data_out_q;

    // ------------------------------------------------------------------
    // Request capture and completion datapath
    // ------------------------------------------------------------------
    always_comb begin
        req_live.we    = req_we;
        req_live.wdata = data_in;
        req_live.mode  = access_mode;
        req_live.uns   = load_unsigned;
    end

    // With LATENCY == 1 the access completes on the accepting edge, so the
    // live inputs are used directly; otherwise the latched copy is used.
    assign req_eff  = (state_q == ST_IDLE) ? req_live : req_q;
    assign addr_eff = (state_q == ST_IDLE) ? addr[ADDR_WIDTH-1:0] : addr_q;

    assign complete = (state_q != ST_DONE) && (state_d == ST_DONE);
    assign mis_eff  = is_misaligned(addr_eff[1:0], req_eff.mode);
    assign rd_word  = ram[addr_eff[ADDR_WIDTH-1:2]];

    dmem_load_align u_align (
        .rd_word       (rd_word),
        .st_data       (req_eff.wdata),
        .addr_lo       (addr_eff[1:0]),
        .mode          (req_eff.mode),
        .load_unsigned (req_eff.uns),
        .load_val      (load_val),
        .wr_word       (wr_word),
        .byte_en       (byte_en)
    );

    always_comb begin
        addr_d     = addr_q;
        req_d      = req_q;
        data_out_d = data_out_q;
        misalign_d = misalign_q;
        lane_we    = 4'b0000;
        if ((state_q == ST_IDLE) && req_valid) begin
            addr_d = addr[ADDR_WIDTH-1:0];
            req_d  = req_live;
        end
        if (complete) begin
            misalign_d = mis_eff;
            if (mis_eff) begin
                data_out_d = 32'd0;
            end else if (req_eff.we) begin
                // The RAM has no reset; keep clock edges seen while reset is
                // held from committing a write.
                lane_we = byte_en & {4{rst_n}};
            end else begin
                data_out_d = load_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // RAM: one word array with four byte lanes, each with its own enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int lane = 0; lane < 4; lane++) begin
            if (lane_we[lane]) begin
                ram[addr_eff[ADDR_WIDTH-1:2]][8*lane +: 8] <= wr_word[8*lane +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid_a, req_valid_b;
    logic        req_we, uns;
    logic [31:0] addr, wdata;
    logic [1:0]  mode;
    logic [31:0] data_out_a, data_out_b;
    logic        stall_a, stall_b, resp_valid_a, resp_valid_b, misalign_a, misalign_b;

    int checks = 0;
    int errors = 0;

    // Reference model: one byte array per DUT (index = dut*65536 + byte addr)
    logic [7:0]  mmem [0:131071];
    logic [31:0] exp_dout [2];

    dmem_responder #(.ADDR_WIDTH(16), .LATENCY(2), .INIT_FILE("")) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_we(req_we),
        .addr(addr), .data_in(wdata), .access_mode(mode), .load_unsigned(uns),
        .data_out(data_out_a), .stall(stall_a), .resp_valid(resp_valid_a),
        .misalign(misalign_a)
    );

    dmem_responder #(.ADDR_WIDTH(16), .LATENCY(1), .INIT_FILE("")) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_we(req_we),
        .addr(addr), .data_in(wdata), .access_mode(mode), .load_unsigned(uns),
        .data_out(data_out_b), .stall(stall_b), .resp_valid(resp_valid_b),
        .misalign(misalign_b)
    );

    function automatic logic get_stall(input bit b);
        return b ? stall_b : stall_a;
    endfunction
    function automatic logic get_resp(input bit b);
        return b ? resp_valid_b : resp_valid_a;
    endfunction
    function automatic logic get_mis(input bit b);
        return b ? misalign_b : misalign_a;
    endfunction
    function automatic logic [31:0] get_dout(input bit b);
        return b ? data_out_b : data_out_a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: byte-granular memory, size = 2^mode bytes.
    function automatic void model_access(input bit b, input bit we, input logic [31:0] a,
                                         input logic [31:0] d, input logic [1:0] m,
                                         input bit u, output logic [31:0] dout,
                                         output bit mis);
        int          size;
        int          base;
        logic [15:0] ba;
        logic [31:0] v;
        size = 1 << m;
        base = b ? 65536 : 0;
        mis  = (m == 2'b11) || ((int'(a[1:0]) % size) != 0);
        dout = exp_dout[b];
        if (mis) begin
            dout = 32'd0;
        end else if (we) begin
            for (int i = 0; i < size; i++) begin
                ba = a[15:0] + 16'(i);
                mmem[base + int'(ba)] = 8'(d >> (8 * i));
            end
        end else begin
            v = 32'd0;
            for (int i = 0; i < size; i++) begin
                ba = a[15:0] + 16'(i);
                v  = v | (32'(mmem[base + int'(ba)]) << (8 * i));
            end
            if (!u && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
            dout = v;
        end
        exp_dout[b] = dout;
    endfunction

    // One access on DUT b; checks stall length, response, misalign, data_out.
    task automatic access(input bit b, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] m, input bit u,
                          input bit hold, input string tag, output logic [31:0] dout_obs);
        int          stalls;
        int          lat;
        bit          got;
        logic [31:0] e_dout;
        bit          e_mis;
        lat    = b ? 1 : 2;
        stalls = 0;
        got    = 1'b0;
        @(negedge clk);
        req_we = we; addr = a; wdata = d; mode = m; uns = u;
        if (b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        #1;
        chk({tag, "/resp_before"}, 32'(get_resp(b)), 32'd0);
        for (int i = 0; i < 20 && !got; i++) begin
            if (get_resp(b)) got = 1'b1;
            else begin
                if (get_stall(b)) stalls++;
                @(negedge clk);
                #1;
            end
        end
        model_access(b, we, a, d, m, u, e_dout, e_mis);
        chk({tag, "/done"}, 32'(got), 32'd1);
        chk({tag, "/stall_cycles"}, 32'(stalls), 32'(lat));
        chk({tag, "/stall_at_done"}, 32'(get_stall(b)), 32'd0);
        chk({tag, "/misalign"}, 32'(get_mis(b)), 32'(e_mis));
        chk({tag, "/data_out"}, get_dout(b), e_dout);
        dout_obs = get_dout(b);
        if (!hold) begin
            if (b) req_valid_b = 1'b0; else req_valid_a = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ra, rd;
        logic [1:0]  rm;
        bit          rw, ru, rh;

        rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_we = 1'b0; addr = '0; wdata = '0; mode = 2'b00; uns = 1'b0;
        exp_dout[0] = 32'd0; exp_dout[1] = 32'd0;

        // Reset and idle
        repeat (2) @(negedge clk);
        #1;
        chk("rst/stall_a", 32'(stall_a), 32'd0);
        chk("rst/resp_a", 32'(resp_valid_a), 32'd0);
        chk("rst/mis_a", 32'(misalign_a), 32'd0);
        chk("rst/dout_a", data_out_a, 32'd0);
        chk("rst/dout_b", data_out_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle/stall_a", 32'(stall_a), 32'd0);
            chk("idle/resp_a", 32'(resp_valid_a), 32'd0);
            chk("idle/mis_a", 32'(misalign_a), 32'd0);
            chk("idle/dout_a", data_out_a, 32'd0);
        end

        // Word store / load
        access(0, 1, 32'h0010, 32'hDEADBEEF, 2'b10, 0, 0, "sw_10", r);
        access(0, 0, 32'h0010, 32'h0, 2'b10, 0, 0, "lw_10", r);
        chk("lw_10/literal", r, 32'hDEADBEEF);

        // Byte/half loads
        access(0, 1, 32'h0020, 32'h80FF7F01, 2'b10, 0, 0, "sw_20", r);
        access(0, 0, 32'h0021, 32'h0, 2'b00, 0, 0, "lb_21", r);
        chk("lb_21/literal", r, 32'h0000007F);
        access(0, 0, 32'h0023, 32'h0, 2'b00, 0, 0, "lb_23", r);
        chk("lb_23/literal", r, 32'hFFFFFF80);
        access(0, 0, 32'h0022, 32'h0, 2'b01, 1, 0, "lhu_22", r);
        chk("lhu_22/literal", r, 32'h000080FF);
        access(0, 0, 32'h0022, 32'h0, 2'b01, 0, 0, "lh_22", r);
        chk("lh_22/literal", r, 32'hFFFF80FF);

        // Byte store merge; data_out must hold across stores
        access(0, 1, 32'h0030, 32'h11223344, 2'b10, 0, 0, "sw_30", r);
        chk("sw_30/dout_hold", r, 32'hFFFF80FF);
        access(0, 1, 32'h0031, 32'h000000AA, 2'b00, 0, 0, "sb_31", r);
        access(0, 0, 32'h0030, 32'h0, 2'b10, 0, 0, "lw_30", r);
        chk("lw_30/literal", r, 32'h1122AA44);

        // Misalignment
        access(0, 1, 32'h0040, 32'h55667788, 2'b10, 0, 0, "sw_40", r);
        access(0, 1, 32'h0042, 32'h12345678, 2'b10, 0, 0, "sw_42_mis", r);
        chk("sw_42_mis/misalign", 32'(misalign_a), 32'd1);
        access(0, 0, 32'h0040, 32'h0, 2'b10, 0, 0, "lw_40", r);
        chk("lw_40/literal", r, 32'h55667788);
        access(0, 0, 32'h0040, 32'h0, 2'b11, 0, 0, "rsvd_40", r);
        chk("rsvd_40/dout", r, 32'd0);
        access(0, 0, 32'h0041, 32'h0, 2'b01, 0, 0, "lh_41_mis", r);

        // Aliasing above ADDR_WIDTH
        access(0, 0, 32'h0001_0010, 32'h0, 2'b10, 0, 0, "lw_alias", r);
        chk("lw_alias/literal", r, 32'hDEADBEEF);
        access(0, 1, 32'hABCD_0050, 32'h0BADF00D, 2'b10, 0, 0, "sw_alias", r);
        access(0, 0, 32'h0000_0050, 32'h0, 2'b10, 0, 0, "lw_50", r);
        chk("lw_50/literal", r, 32'h0BADF00D);

        // Reset while BUSY during a store: no write may land
        @(negedge clk);
        req_we = 1'b1; addr = 32'h0010; wdata = 32'hCAFEF00D; mode = 2'b10; uns = 1'b0;
        req_valid_a = 1'b1;
        @(negedge clk);
        #1;
        chk("rstbusy/stall_in_busy", 32'(stall_a), 32'd1);
        rst_n = 1'b0;
        req_valid_a = 1'b0;
        #1;
        chk("rstbusy/stall", 32'(stall_a), 32'd0);
        chk("rstbusy/resp", 32'(resp_valid_a), 32'd0);
        chk("rstbusy/dout", data_out_a, 32'd0);
        exp_dout[0] = 32'd0; exp_dout[1] = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rstbusy/idle_stall", 32'(stall_a), 32'd0);
        access(0, 0, 32'h0010, 32'h0, 2'b10, 0, 0, "lw_after_rst", r);
        chk("lw_after_rst/literal", r, 32'hDEADBEEF);

        // LATENCY=1 back-to-back with req_valid held
        access(1, 1, 32'h0010, 32'h01234567, 2'b10, 0, 1, "b2b_sw0", r);
        access(1, 1, 32'h0014, 32'h89ABCDEF, 2'b10, 0, 1, "b2b_sw1", r);
        access(1, 1, 32'h0016, 32'h0000FEDC, 2'b01, 0, 1, "b2b_sh", r);
        access(1, 0, 32'h0001_0010, 32'h0, 2'b10, 0, 1, "b2b_lw_alias", r);
        chk("b2b_lw_alias/literal", r, 32'h01234567);
        access(1, 0, 32'h0014, 32'h0, 2'b10, 0, 1, "b2b_lw1", r);
        chk("b2b_lw1/literal", r, 32'hFEDCCDEF);
        access(1, 0, 32'h0017, 32'h0, 2'b00, 0, 0, "b2b_lb", r);
        chk("b2b_lb/literal", r, 32'hFFFFFFFE);

        // Randomized traffic against the model on both latencies
        for (int i = 0; i < 16; i++) begin
            access(0, 1, 32'h0100 + 32'(4 * i), $urandom, 2'b10, 0, 0, "rnd_init_a", r);
            access(1, 1, 32'h0100 + 32'(4 * i), $urandom, 2'b10, 0, 0, "rnd_init_b", r);
        end
        for (int i = 0; i < 60; i++) begin
            ra = {16'($urandom), 16'h0100 + 16'($urandom_range(0, 63))};
            rd = $urandom;
            rm = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1));
            access(0, rw, ra, rd, rm, ru, 0, "rnd_a", r);
        end
        for (int i = 0; i < 40; i++) begin
            ra = {16'($urandom), 16'h0100 + 16'($urandom_range(0, 63))};
            rd = $urandom;
            rm = 2'($urandom_range(0, 3));
            rw = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1));
            rh = (i != 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            access(1, rw, ra, rd, rm, ru, rh, "rnd_b", r);
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
